// File: rtl/bp_pkg.sv
// ---------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the gshare branch predictor blocks.
//   - 2-bit saturating counter encodings and reset value
//   - ctr_update(): saturating increment/decrement of one counter
//   - inflight_t: entry held between prediction and resolve {index, pred}
// ---------------------------------------------------------------------------
package bp_pkg;

   // Index width of the pattern history table (the table holds 2**BP_IDX_W counters).
   localparam int BP_IDX_W = 4;

   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] CTR_RESET = CTR_WNT;

   typedef struct packed {
      logic [BP_IDX_W-1:0] index;
      logic                pred;
   } inflight_t;

   // Move the counter one step toward the resolved outcome and saturate at both ends.
   function automatic logic [1:0] ctr_update(input logic [1:0] c, input logic taken);
      if (taken)
         return (c == CTR_ST)  ? CTR_ST  : c + 2'd1;
      else
         return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
   endfunction

endpackage

// File: rtl/pht_inflight_fifo.sv
// ---------------------------------------------------------------------------
// pht_inflight_fifo
// In-order buffer of predicted-but-unresolved branches.
//   clk, reset    : rising-edge clock, synchronous active-high reset
//   push/push_data: enqueue (ignored when full)
//   pop/pop_data  : dequeue the oldest entry; pop_data shows the head at all times
//   full, empty   : derived from the registered occupancy
//   count         : occupancy 0..DEPTH
// DEPTH must be a power of two, so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module pht_inflight_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  inflight_t                push_data,
   input  logic                     pop,
   output inflight_t                pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   inflight_t          mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               do_push;
   logic               do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/pht_table.sv
// ---------------------------------------------------------------------------
// pht_table
// Pattern history table for the gshare predictor. Each lookup reads a 2-bit
// counter and returns a registered prediction. The index and the prediction
// are queued so that the counter is trained at resolve time with the index
// captured at prediction time.
//   clk, reset                : rising-edge clock, synchronous active-high reset
//   lookup_valid/index/ready  : lookup handshake (accepted iff valid && ready)
//   pred_valid/pred_taken     : one-cycle registered prediction
//   resolve_valid/taken       : outcome of the oldest in-flight branch
//   mispredict                : one-cycle pulse, stored prediction != outcome
//   underflow_err             : sticky, a resolve arrived with nothing in flight
//   inflight_count            : buffer occupancy
// Optional build macro PHT_STATS_EN adds stat_lookups / stat_mispredicts
// (16-bit saturating counters).
// ---------------------------------------------------------------------------
module pht_table
   import bp_pkg::*;
#(
   parameter int IDX_W = BP_IDX_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     lookup_valid,
   input  logic [IDX_W-1:0]         lookup_index,
   output logic                     lookup_ready,
   output logic                     pred_valid,
   output logic                     pred_taken,
   input  logic                     resolve_valid,
   input  logic                     resolve_taken,
   output logic                     mispredict,
   output logic                     underflow_err,
   output logic [$clog2(DEPTH):0]   inflight_count
`ifdef PHT_STATS_EN
   ,
   output logic [15:0]              stat_lookups,
   output logic [15:0]              stat_mispredicts
`endif
);

   localparam int ENTRIES = 2 ** IDX_W;

   logic [1:0]  ctr [ENTRIES];
   logic        fifo_full;
   logic        fifo_empty;
   inflight_t   head;
   inflight_t   push_ent;
   logic        accept;
   logic        pop;
   logic        lookup_pred;
   logic        misp_nxt;

   // Ready depends only on the registered occupancy, so a same-cycle pop
   // never frees a slot for the lookup arriving in that cycle.
   assign lookup_ready = !fifo_full;
   assign accept       = lookup_valid && lookup_ready;
   assign pop          = resolve_valid && !fifo_empty;
   assign lookup_pred  = ctr[lookup_index][1];
   assign misp_nxt     = pop && (head.pred ^ resolve_taken);

   assign push_ent.index = lookup_index;
   assign push_ent.pred  = lookup_pred;

   pht_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (accept),
      .push_data (push_ent),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (inflight_count)
   );

   // Counter training. The lookup read above is combinational from the old
   // array contents, so a lookup of the index being trained in the same cycle
   // sees the pre-update value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_RESET;
      end else if (pop) begin
         ctr[head.index] <= ctr_update(ctr[head.index], resolve_taken);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pred_valid    <= 1'b0;
         pred_taken    <= 1'b0;
         mispredict    <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         pred_valid    <= accept;
         pred_taken    <= accept && lookup_pred;
         mispredict    <= misp_nxt;
         if (resolve_valid && fifo_empty) underflow_err <= 1'b1;
      end
   end

`ifdef PHT_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_lookups     <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (accept && stat_lookups != 16'hFFFF)
            stat_lookups <= stat_lookups + 16'd1;
         if (misp_nxt && stat_mispredicts != 16'hFFFF)
            stat_mispredicts <= stat_mispredicts + 16'd1;
      end
   end
`endif

endmodule
